hazard_ctrl: RTL
================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline control unit that drives the enable/flush inputs of the IF/ID, ID/EX, EX/MEM and
//  MEM/WB registers and the PC write enable. Sits beside the datapath; it resolves stalls and
//  flushes for: data-memory waits, load-use hazards, instruction-fetch misses, taken branches
//  and halt. Small FSM (RUN/DWAIT/HALT) plus saturating stall and flush counters for perf debug.
// PARAMETERS
//  CNT_W  32  width of stall_cnt and flush_cnt
// PORTS
//  CLK            in   1      clock, rising edge
//  nRST           in   1      reset, asynchronous, active-low
//  ihit           in   1      instruction fetch complete this cycle
//  dhit           in   1      data access complete this cycle
//  dmem_req_MEM   in   1      EX/MEM holds load or store (dREN|dWEN)
//  dREN_ID_EX     in   1      ID/EX holds a load
//  Rt_ID_EX       in   5      load destination register in ID/EX
//  Rs_IF_ID       in   5      rs field of instruction in IF/ID
//  Rt_IF_ID       in   5      rt field of instruction in IF/ID
//  branch_taken   in   1      branch/jump resolved taken in EX; PC mux selects target
//  halt_MEM_WB    in   1      halt instruction has reached MEM/WB
//  pc_en          out  1      PC register loads next PC
//  enable_IF_ID   out  1      IF/ID register captures
//  flush_IF_ID    out  1      IF/ID loads a bubble (overrides enable)
//  enable_ID_EX   out  1      ID/EX register captures
//  flush_ID_EX    out  1      ID/EX loads a bubble (overrides enable)
//  enable_EX_MEM  out  1      EX/MEM register captures
//  flush_EX_MEM   out  1      EX/MEM loads a bubble (overrides enable)
//  enable_MEM_WB  out  1      MEM/WB register captures
//  halt           out  1      sticky CPU halted flag
//  stall_cnt      out  CNT_W  cycles with pc_en=0 while not HALT, saturating
//  flush_cnt      out  CNT_W  cycles with branch flush issued, saturating
// BEHAVIOUR
//  Reset: state=RUN, counters=0, halt=0. While nRST=0 all enables, pc_en and flushes are 0.
//  Outputs are combinational from state and inputs (same-cycle). Counters and state update on CLK.
//  Terms:
//    dwait = dmem_req_MEM & ~dhit
//    lu    = dREN_ID_EX & (Rt_ID_EX!=0) & (Rt_ID_EX==Rs_IF_ID | Rt_ID_EX==Rt_IF_ID)
//    ifmiss = ~ihit
//  Default (RUN, no event): all enables=1, pc_en=1, all flushes=0.
//  Priority in RUN and DWAIT (first match wins):
//   1 dwait: freeze. All enables=0, pc_en=0, flushes=0. Next state DWAIT.
//   2 branch_taken: pc_en=1, flush_IF_ID=1, flush_ID_EX=1, other enables=1; flush_cnt++.
//   3 lu: pc_en=0, enable_IF_ID=0, flush_ID_EX=1, EX/MEM and MEM/WB enabled.
//   4 ifmiss: pc_en=0, flush_IF_ID=1, downstream enabled (bubble enters IF/ID).
//  - DWAIT: leaves to RUN in the cycle dhit=1. In that cycle, rules 2-4/default apply normally.
//  - Data memory has priority over fetch. ifmiss is ignored (no bubble) while dwait=1.
//  - halt_MEM_WB=1 in any state: next state HALT; that cycle all enables=0, pc_en=0.
//  - HALT: all enables, pc_en and flushes=0. halt=1. No counter updates. Left only by reset.
//  - stall_cnt += 1 on every non-HALT cycle with pc_en=0. Both counters hold at 2^CNT_W-1.
//  - Reset mid-stall: returns to RUN at once. Any pending freeze or bubble is dropped.
// TESTING
//  1 lw r5 in ID/EX, add r6,r5,r1 in IF/ID, ihit=1 -> one cycle pc_en=0, enable_IF_ID=0,
//    flush_ID_EX=1. Next cycle all enables=1. stall_cnt=1.
//  2 dmem_req_MEM=1, dhit=0 for 3 cycles then 1 -> 3 freeze cycles (all enables 0),
//    state DWAIT, then RUN. stall_cnt=3. No flush asserted.
//  3 branch_taken=1 together with lu=1 -> branch wins. flush_IF_ID=flush_ID_EX=1, pc_en=1,
//    flush_cnt=1.
//  4 ifmiss=1 with dwait=1 -> freeze only, flush_IF_ID=0. After dhit, ihit=0 -> flush_IF_ID=1.
//  5 halt_MEM_WB=1 -> halt=1 next cycle and all enables 0. Toggle other inputs: outputs unchanged.
//    Pulse nRST -> halt=0, counters 0, RUN.
//  6 CNT_W=4, hold ihit=0 for 20 cycles -> stall_cnt saturates at 15.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stage enables, bubbles and PC write for dmem waits, load-use, fetch misses, branches, halt.
// Control outputs are combinational from state and inputs; state and perf counters update on CLK.
module hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             dmem_req_MEM,
  input  logic             dREN_ID_EX,
  input  logic [4:0]       Rt_ID_EX,
  input  logic [4:0]       Rs_IF_ID,
  input  logic [4:0]       Rt_IF_ID,
  input  logic             branch_taken,
  input  logic             halt_MEM_WB,
  output logic             pc_en,
  output logic             enable_IF_ID,
  output logic             flush_IF_ID,
  output logic             enable_ID_EX,
  output logic             flush_ID_EX,
  output logic             enable_EX_MEM,
  output logic             flush_EX_MEM,
  output logic             enable_MEM_WB,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DWAIT = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t state, next_state;

  logic dwait, lu, ifmiss;
  logic br_flush;

  assign dwait  = dmem_req_MEM & ~dhit;
  assign lu     = dREN_ID_EX & (Rt_ID_EX != 5'd0) &
                  ((Rt_ID_EX == Rs_IF_ID) | (Rt_ID_EX == Rt_IF_ID));
  assign ifmiss = ~ihit;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= RUN;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (state == HALT || halt_MEM_WB) next_state = HALT;
    else if (dwait)                   next_state = DWAIT;
    else                              next_state = RUN;
  end

  // Gating on nRST keeps every register frozen while reset is held.
  always_comb begin
    pc_en         = 1'b0;
    enable_IF_ID  = 1'b0;
    flush_IF_ID   = 1'b0;
    enable_ID_EX  = 1'b0;
    flush_ID_EX   = 1'b0;
    enable_EX_MEM = 1'b0;
    flush_EX_MEM  = 1'b0;
    enable_MEM_WB = 1'b0;
    halt          = 1'b0;
    br_flush      = 1'b0;
    if (!nRST) begin
      halt = 1'b0;
    end else if (state == HALT) begin
      halt = 1'b1;
    end else if (halt_MEM_WB || dwait) begin
      halt = 1'b0;
    end else begin
      pc_en         = 1'b1;
      enable_IF_ID  = 1'b1;
      enable_ID_EX  = 1'b1;
      enable_EX_MEM = 1'b1;
      enable_MEM_WB = 1'b1;
      if (branch_taken) begin
        flush_IF_ID = 1'b1;
        flush_ID_EX = 1'b1;
        br_flush    = 1'b1;
      end else if (lu) begin
        pc_en        = 1'b0;
        enable_IF_ID = 1'b0;
        flush_ID_EX  = 1'b1;
      end else if (ifmiss) begin
        pc_en       = 1'b0;
        flush_IF_ID = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (state != HALT) begin
      if (!pc_en && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
      if (br_flush && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule
